// File: rtl/rvfi_pkg.sv
// Shared types, widths and the lane priority encoder for the RVFI retire serializer.
package rvfi_pkg;

  localparam int ORDER_W = 8;
  localparam int LANE_W  = 3;

  typedef enum logic {
    ST_IDLE,
    ST_DRAIN
  } st_t;

  // Lowest set bit of mask at or above from. Bit 3 of the result is set when no such bit exists.
  function automatic logic [LANE_W:0] rvfi_lane_sel(input logic [7:0] mask,
                                                    input logic [LANE_W-1:0] from);
    logic [LANE_W:0] sel;
    sel = 4'd8;
    for (int i = 7; i >= 0; i--) begin
      if (mask[i] && (3'(i) >= from)) sel = 4'(i);
    end
    return sel;
  endfunction

endpackage

// File: rtl/rvfi_bundle_fifo.sv
// Bundle FIFO: stores valid mask, orders and records per retirement bundle.
// The head entry's mask can be trimmed in place as lanes are replayed.
module rvfi_bundle_fifo
  import rvfi_pkg::*;
#(
  parameter int NRET  = 2,
  parameter int REC_W = 256,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic [NRET-1:0]            push_mask_i,
  input  logic [NRET*ORDER_W-1:0]    push_order_i,
  input  logic [NRET*REC_W-1:0]      push_rec_i,
  input  logic                       pop_i,
  input  logic                       clr_i,
  input  logic [NRET-1:0]            clr_mask_i,
  output logic [NRET-1:0]            head_mask_o,
  output logic [NRET*ORDER_W-1:0]    head_order_o,
  output logic [NRET*REC_W-1:0]      head_rec_o,
  output logic [CNT_W-1:0]           count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [NRET-1:0]         mask_mem  [DEPTH];
  logic [NRET*ORDER_W-1:0] order_mem [DEPTH];
  logic [NRET*REC_W-1:0]   rec_mem   [DEPTH];
  logic [PW-1:0]           wr_q, rd_q;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  // Occupancy next-state: simultaneous push and pop leave the count unchanged.
  always_comb begin
    cnt_d = cnt_q;
    if (push_i && !pop_i)      cnt_d = cnt_q + 1'b1;
    else if (!push_i && pop_i) cnt_d = cnt_q - 1'b1;
  end

  // Storage, pointers and head-mask trimming.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) begin
        mask_mem[wr_q]  <= push_mask_i;
        order_mem[wr_q] <= push_order_i;
        rec_mem[wr_q]   <= push_rec_i;
        wr_q            <= wr_q + 1'b1;
      end
      if (pop_i)      rd_q <= rd_q + 1'b1;
      else if (clr_i) mask_mem[rd_q] <= mask_mem[rd_q] & ~clr_mask_i;
      cnt_q <= cnt_d;
    end
  end

  assign head_mask_o  = mask_mem[rd_q];
  assign head_order_o = order_mem[rd_q];
  assign head_rec_o   = rec_mem[rd_q];
  assign count_o      = cnt_q;

endmodule

// File: rtl/rvfi_retire_serializer.sv
// Serializes multi-channel RVFI retirement bundles into one record per handshake
// and flags discontinuities in the order stream.
//
//   state    | meaning
//   ST_IDLE  | FIFO empty, nothing presented
//   ST_DRAIN | head bundle present, presenting its next valid lane
module rvfi_retire_serializer
  import rvfi_pkg::*;
#(
  parameter int NRET  = 2,
  parameter int REC_W = 256,
  parameter int DEPTH = 4
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NRET-1:0]                       in_valid,
  input  logic [NRET*ORDER_W-1:0]               in_order,
  input  logic [NRET*REC_W-1:0]                 in_rec,
  output logic                                  in_ready,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [REC_W-1:0]                      out_rec,
  output logic [ORDER_W-1:0]                    out_order,
  output logic [((NRET > 1) ? $clog2(NRET) : 1)-1:0] out_chidx,
  output logic                                  err_order,
  output logic                                  busy
);

  localparam int CHW   = (NRET > 1) ? $clog2(NRET) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  st_t                     st_q, st_d;
  logic [LANE_W-1:0]       lane_q, lane_d;
  logic                    exp_vld_q, exp_vld_d;
  logic [ORDER_W-1:0]      exp_order_q, exp_order_d;
  logic                    err_q, err_d;

  logic [NRET-1:0]         head_mask;
  logic [NRET*ORDER_W-1:0] head_order;
  logic [NRET*REC_W-1:0]   head_rec;
  logic [CNT_W-1:0]        count;
  logic [7:0]              mask_ext;
  logic [LANE_W:0]         sel;
  logic [LANE_W-1:0]       enc;
  logic                    found, hs, last, push, pop, clr;
  logic [NRET-1:0]         clr_mask;

  rvfi_bundle_fifo #(
    .NRET (NRET),
    .REC_W(REC_W),
    .DEPTH(DEPTH),
    .CNT_W(CNT_W)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .push_mask_i (in_valid),
    .push_order_i(in_order),
    .push_rec_i  (in_rec),
    .pop_i       (pop),
    .clr_i       (clr),
    .clr_mask_i  (clr_mask),
    .head_mask_o (head_mask),
    .head_order_o(head_order),
    .head_rec_o  (head_rec),
    .count_o     (count)
  );

  // Lane selection and handshake bookkeeping for the head bundle.
  always_comb begin
    mask_ext             = '0;
    mask_ext[NRET-1:0]   = head_mask;
    sel                  = rvfi_lane_sel(mask_ext, lane_q);
    enc                  = sel[LANE_W-1:0];
    found                = ~sel[LANE_W];
    for (int c = 0; c < NRET; c++) clr_mask[c] = (enc == 3'(c));
    in_ready  = (count < CNT_W'(DEPTH));
    out_valid = (st_q == ST_DRAIN);
    push      = (|in_valid) & in_ready;
    hs        = out_valid & out_ready & found;
    last      = ((head_mask & ~clr_mask) == '0);
    pop       = hs & last;
    clr       = hs & ~last;
    busy      = (count != '0);
    err_order = err_q;
  end

  // Output mux: zero whenever nothing is presented.
  always_comb begin
    out_rec   = '0;
    out_order = '0;
    out_chidx = '0;
    if (out_valid && found) begin
      for (int c = 0; c < NRET; c++) begin
        if (enc == 3'(c)) begin
          out_rec   = head_rec[c*REC_W +: REC_W];
          out_order = head_order[c*ORDER_W +: ORDER_W];
          out_chidx = CHW'(c);
        end
      end
    end
  end

  // Next-state for drain FSM, lane pointer and order checker.
  always_comb begin
    st_d        = st_q;
    lane_d      = lane_q;
    exp_vld_d   = exp_vld_q;
    exp_order_d = exp_order_q;
    err_d       = err_q;
    case (st_q)
      ST_IDLE: begin
        lane_d = '0;
        if (push) st_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (hs) lane_d = last ? '0 : enc + 3'd1;
        if (pop && !push && count == CNT_W'(1)) st_d = ST_IDLE;
      end
      default: st_d = ST_IDLE;
    endcase
    if (hs) begin
      if (exp_vld_q && out_order != exp_order_q) err_d = 1'b1;
      exp_vld_d   = 1'b1;
      exp_order_d = out_order + 8'd1;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q        <= ST_IDLE;
      lane_q      <= '0;
      exp_vld_q   <= 1'b0;
      exp_order_q <= '0;
      err_q       <= 1'b0;
    end else begin
      st_q        <= st_d;
      lane_q      <= lane_d;
      exp_vld_q   <= exp_vld_d;
      exp_order_q <= exp_order_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_rvfi_retire_serializer.sv
// Bench for rvfi_retire_serializer: queue-based reference model plus directed and random stimulus.
module tb_rvfi_retire_serializer;

  localparam int NRET  = 2;
  localparam int REC_W = 256;
  localparam int DEPTH = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic [NRET-1:0]     in_valid;
  logic [NRET*8-1:0]   in_order;
  logic [NRET*REC_W-1:0] in_rec;
  logic                in_ready, out_valid, out_ready;
  logic [REC_W-1:0]    out_rec;
  logic [7:0]          out_order;
  logic [0:0]          out_chidx;
  logic                err_order, busy;

  rvfi_retire_serializer #(.NRET(NRET), .REC_W(REC_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_order(in_order), .in_rec(in_rec),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready), .out_rec(out_rec),
    .out_order(out_order), .out_chidx(out_chidx), .err_order(err_order), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]       order;
    logic [REC_W-1:0] rec;
    int               ch;
    bit               last;
  } item_t;

  item_t      q[$];
  int         m_bundles;
  bit         m_exp_vld;
  logic [7:0] m_exp;
  bit         m_err;
  int         got[$];
  bit         last_acc;
  int         n_vec = 0;
  int         n_bad = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void chk_rec(logic [REC_W-1:0] act, logic [REC_W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL out_rec: got %h expected %h", act, exp);
    end
  endfunction

  function automatic void model_clear();
    q.delete();
    m_bundles = 0;
    m_exp_vld = 0;
    m_exp     = '0;
    m_err     = 0;
  endfunction

  // One clock: compare at the negedge, then apply the spec rules to the model at the posedge.
  task automatic cycle();
    bit acc, hs;
    item_t it;
    int nlast;
    chk("in_ready", in_ready, m_bundles < DEPTH);
    chk("busy", busy, m_bundles != 0);
    chk("out_valid", out_valid, q.size() != 0);
    chk("err_order", err_order, m_err);
    if (q.size() != 0) begin
      chk("out_order", out_order, q[0].order);
      chk("out_chidx", out_chidx, q[0].ch);
      chk_rec(out_rec, q[0].rec);
    end else begin
      chk("idle_order", out_order, 0);
      chk("idle_chidx", out_chidx, 0);
      chk_rec(out_rec, '0);
    end
    acc = (in_valid != 0) && (m_bundles < DEPTH);
    hs  = (q.size() != 0) && out_ready;
    @(posedge clk);
    last_acc = acc && !reset;
    if (reset) begin
      model_clear();
    end else begin
      if (hs) begin
        it = q.pop_front();
        got.push_back(int'(out_order));
        if (m_exp_vld && it.order != m_exp) m_err = 1;
        m_exp     = it.order + 8'd1;
        m_exp_vld = 1;
        if (it.last) m_bundles--;
      end
      if (acc) begin
        nlast = -1;
        for (int c = 0; c < NRET; c++) if (in_valid[c]) nlast = c;
        for (int c = 0; c < NRET; c++) begin
          if (in_valid[c]) begin
            it.order = in_order[c*8 +: 8];
            it.rec   = in_rec[c*REC_W +: REC_W];
            it.ch    = c;
            it.last  = (c == nlast);
            q.push_back(it);
          end
        end
        m_bundles++;
      end
    end
    @(negedge clk);
  endtask

  task automatic set_bundle(logic [NRET-1:0] v, int o0, int o1);
    in_valid = v;
    in_order = {8'(o1), 8'(o0)};
    for (int w = 0; w < NRET*REC_W/32; w++) in_rec[w*32 +: 32] = $urandom;
  endtask

  task automatic do_reset();
    in_valid = '0;
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    int nxt, hold;
    reset = 1'b1; in_valid = '0; in_order = '0; in_rec = '0; out_ready = 1'b1;
    model_clear();
    @(negedge clk);
    cycle();
    reset = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_order, 0);

    // two-lane bundle, orders 5,6
    set_bundle(2'b11, 5, 6); cycle(); in_valid = '0;
    chk("t1_order0", out_order, 5); chk("t1_ch0", out_chidx, 0); chk("t1_valid", out_valid, 1);
    cycle();
    chk("t1_order1", out_order, 6); chk("t1_ch1", out_chidx, 1);
    cycle();
    chk("t1_busy", busy, 0); chk("t1_err", err_order, 0);

    // lane 0 invalid: no idle cycle, chidx 1
    set_bundle(2'b10, 99, 7); cycle(); in_valid = '0;
    chk("t2_valid", out_valid, 1); chk("t2_ch", out_chidx, 1); chk("t2_order", out_order, 7);
    cycle();
    chk("t2_busy", busy, 0); chk("t2_err", err_order, 0);

    // back-pressure: fill the FIFO, hold the 5th bundle, then drain 0..9
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin set_bundle(2'b11, 2*i, 2*i+1); cycle(); end
    chk("t3_full_ready", in_ready, 0);
    set_bundle(2'b11, 8, 9); cycle(); cycle();
    chk("t3_held_ready", in_ready, 0); chk("t3_busy", busy, 1);
    got.delete();
    out_ready = 1'b1;
    hold = 0;
    while (((in_valid != 0) || q.size() != 0) && hold < 30) begin
      cycle(); hold++;
      if (last_acc) in_valid = '0;
    end
    chk("t3_timeout", hold < 30, 1);
    chk("t3_count", got.size(), 10);
    for (int i = 0; i < 10 && i < got.size(); i++) chk("t3_seq", got[i], i);

    // wrap 255 -> 0 is not an error
    do_reset();
    set_bundle(2'b11, 254, 255); cycle();
    set_bundle(2'b11, 0, 1); cycle(); in_valid = '0;
    for (int i = 0; i < 4; i++) cycle();
    chk("t4_wrap_err", err_order, 0);

    // gap 3 -> 5 sets a sticky error the cycle after the handshake
    do_reset();
    set_bundle(2'b11, 3, 5); cycle(); in_valid = '0;
    cycle();
    chk("t4_err_before", err_order, 0);
    cycle();
    chk("t4_err_after", err_order, 1);
    set_bundle(2'b11, 6, 7); cycle(); in_valid = '0;
    for (int i = 0; i < 3; i++) cycle();
    chk("t4_err_sticky", err_order, 1);

    // reset while lane 1 is pending
    do_reset();
    set_bundle(2'b11, 20, 21); cycle(); in_valid = '0;
    cycle();
    chk("t5_lane1_order", out_order, 21);
    reset = 1'b1; cycle(); reset = 1'b0;
    got.delete();
    chk("t5_valid", out_valid, 0); chk("t5_busy", busy, 0); chk("t5_ready", in_ready, 1);
    set_bundle(2'b01, 40, 0); cycle(); in_valid = '0;
    cycle(); cycle();
    chk("t5_err", err_order, 0);
    chk("t5_n", got.size(), 1);
    if (got.size() != 0) chk("t5_order", got[0], 40);

    // all-zero in_valid is never stored
    for (int i = 0; i < 10; i++) begin
      in_valid = '0; in_order = 8'(i); cycle();
      chk("t6_valid", out_valid, 0); chk("t6_busy", busy, 0);
    end

    // random traffic with occasional order gaps and one mid-run reset
    do_reset();
    nxt = 100;
    for (int i = 0; i < 600; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (in_valid == '0 || last_acc) begin
        logic [NRET-1:0] v;
        int o0, o1;
        v = NRET'($urandom_range(0, 3));
        if ($urandom_range(0, 39) == 0) nxt++;
        o0 = nxt; o1 = v[0] ? nxt + 1 : nxt;
        nxt = nxt + int'(v[0]) + int'(v[1]);
        set_bundle(v, o0, o1);
      end
      reset = (i == 300);
      cycle();
      if (reset) last_acc = 1'b0;
    end
    reset = 1'b0; in_valid = '0; out_ready = 1'b1;
    for (int i = 0; i < 12; i++) cycle();
    chk("final_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
